// File: rtl/lab05_pkg.sv
// rtl/lab05_pkg.sv - shared states, sizes and parameter-entry layout for the frame/parameter driver
package lab05_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        GAP,
        PFETCH,
        PARAM,
        WAIT,
        FIN
    } state_t;

    localparam int FRAMES        = 16;
    localparam int PIX_PER_FRAME = 1024;
    localparam int OUT_PER_INDEX = 1024;
    localparam int TOT_PIX       = FRAMES * PIX_PER_FRAME;

    localparam int ADDR_W = 14;
    localparam int PIX_W  = 8;
    localparam int IDX_W  = 4;
    localparam int QP_W   = 5;
    localparam int PRM_W  = 9;
    localparam int RES_W  = 32;

    // Parameter entry: {QP[4:0], m3, m2, m1, m0}
    localparam int PRM_MODE_LSB = 0;
    localparam int PRM_MODE_MSB = 3;
    localparam int PRM_QP_LSB   = 4;
    localparam int PRM_QP_MSB   = 8;

endpackage

// File: rtl/frame_param_driver_if.sv
// rtl/frame_param_driver_if.sv - frame/parameter stream between the driver and the transform core
interface frame_param_driver_if;
    import lab05_pkg::*;

    logic              in_valid_data;
    logic [PIX_W-1:0]  data;
    logic              in_valid_param;
    logic [IDX_W-1:0]  index;
    logic              mode;
    logic [QP_W-1:0]   QP;
    logic              out_valid;
    logic [RES_W-1:0]  out_value;

    modport master (
        output in_valid_data, data, in_valid_param, index, mode, QP,
        input  out_valid, out_value
    );

    modport slave (
        input  in_valid_data, data, in_valid_param, index, mode, QP,
        output out_valid, out_value
    );

endinterface

// File: rtl/frame_param_driver.sv
// rtl/frame_param_driver.sv - streams pixel frames and parameter bursts to the core, sums its results
module frame_param_driver
    import lab05_pkg::*;
#(
    parameter int TIMEOUT = 20000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [PIX_W-1:0]      mem_rdata,
    output logic [IDX_W-1:0]      prm_addr,
    input  logic [PRM_W-1:0]      prm_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [RES_W-1:0]      checksum,
    output logic                  timeout_err,
    output logic                  overlap_err,
    frame_param_driver_if.master  core
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0]    WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [9:0]        RESP_LAST = 10'(OUT_PER_INDEX - 1);
    localparam logic [IDX_W-1:0]  K_LAST    = IDX_W'(FRAMES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(TOT_PIX - 1);

    state_t state, state_next;

    logic              pix_req;
    logic              pix_rsp;
    logic [IDX_W-1:0]  k;
    logic [1:0]        pcnt;
    logic [3:0]        modes_q;
    logic [9:0]        resp_cnt;
    logic [WCW-1:0]    wait_cnt;
    logic              burst_done;
    logic              wait_expire;

    logic              in_valid_data_q;
    logic [PIX_W-1:0]  data_q;
    logic              in_valid_param_q;
    logic [IDX_W-1:0]  index_q;
    logic              mode_q;
    logic [QP_W-1:0]   qp_q;

    assign core.in_valid_data  = in_valid_data_q;
    assign core.data           = data_q;
    assign core.in_valid_param = in_valid_param_q;
    assign core.index          = index_q;
    assign core.mode           = mode_q;
    assign core.QP             = qp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        burst_done  = 1'b0;
        wait_expire = 1'b0;
        unique case (state)
            IDLE:   if (start) state_next = DATA;
            // Leave once the final read has come back and nothing more is in flight
            DATA:   if (pix_rsp && !pix_req) state_next = GAP;
            GAP:    state_next = PFETCH;
            PFETCH: if (!core.out_valid) state_next = PARAM;
            PARAM:  if (pcnt == 2'd3) state_next = WAIT;
            WAIT: begin
                if (core.out_valid && resp_cnt == RESP_LAST) begin
                    burst_done = 1'b1;
                    state_next = (k == K_LAST) ? FIN : PFETCH;
                end else if (wait_cnt == WAIT_LAST) begin
                    wait_expire = 1'b1;
                    state_next  = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr         <= '0;
            prm_addr         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            checksum         <= '0;
            timeout_err      <= 1'b0;
            overlap_err      <= 1'b0;
            pix_req          <= 1'b0;
            pix_rsp          <= 1'b0;
            k                <= '0;
            pcnt             <= '0;
            modes_q          <= '0;
            resp_cnt         <= '0;
            wait_cnt         <= '0;
            in_valid_data_q  <= 1'b0;
            data_q           <= '0;
            in_valid_param_q <= 1'b0;
            index_q          <= '0;
            mode_q           <= 1'b0;
            qp_q             <= '0;
        end else begin
            // Strobes and their payloads return to zero unless a state drives them
            in_valid_data_q  <= 1'b0;
            data_q           <= '0;
            in_valid_param_q <= 1'b0;
            index_q          <= '0;
            mode_q           <= 1'b0;
            qp_q             <= '0;
            done             <= 1'b0;

            if (core.out_valid && (in_valid_data_q || in_valid_param_q)) begin
                overlap_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        checksum    <= '0;
                        timeout_err <= 1'b0;
                        overlap_err <= 1'b0;
                        mem_addr    <= '0;
                        prm_addr    <= '0;
                        pix_req     <= 1'b1;
                        pix_rsp     <= 1'b0;
                        k           <= '0;
                        pcnt        <= '0;
                        resp_cnt    <= '0;
                        wait_cnt    <= '0;
                    end
                end
                DATA: begin
                    in_valid_data_q <= pix_rsp;
                    data_q          <= pix_rsp ? mem_rdata : '0;
                    pix_rsp         <= pix_req;
                    if (pix_req) begin
                        mem_addr <= mem_addr + 14'd1;
                        pix_req  <= (mem_addr != ADDR_LAST);
                    end
                end
                GAP: begin
                    prm_addr <= k;
                end
                PFETCH: begin
                    pcnt <= '0;
                end
                PARAM: begin
                    in_valid_param_q <= 1'b1;
                    if (pcnt == 2'd0) begin
                        index_q <= k;
                        qp_q    <= prm_rdata[PRM_QP_MSB:PRM_QP_LSB];
                        mode_q  <= prm_rdata[PRM_MODE_LSB];
                        modes_q <= prm_rdata[PRM_MODE_MSB:PRM_MODE_LSB];
                    end else begin
                        mode_q <= modes_q[pcnt];
                    end
                    pcnt     <= pcnt + 2'd1;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (core.out_valid) begin
                        resp_cnt <= resp_cnt + 10'd1;
                        checksum <= checksum + core.out_value;
                    end
                    if (burst_done) begin
                        resp_cnt <= '0;
                        if (k != K_LAST) begin
                            k        <= k + 1'b1;
                            prm_addr <= k + 1'b1;
                        end
                    end
                    if (wait_expire) begin
                        timeout_err <= 1'b1;
                    end
                    if (state_next == FIN) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_param_driver.sv
// tb/tb_frame_param_driver.sv - scoreboard bench for frame_param_driver with a behavioural core model
module tb_frame_param_driver;
    import lab05_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_rdata;
    logic [IDX_W-1:0]  prm_addr;
    logic [PRM_W-1:0]  prm_rdata;
    logic              busy;
    logic              done;
    logic [RES_W-1:0]  checksum;
    logic              timeout_err;
    logic              overlap_err;

    frame_param_driver_if ifc();

    frame_param_driver dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .prm_addr    (prm_addr),
        .prm_rdata   (prm_rdata),
        .busy        (busy),
        .done        (done),
        .checksum    (checksum),
        .timeout_err (timeout_err),
        .overlap_err (overlap_err),
        .core        (ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic        to;
        logic        ov;
    } done_t;

    logic [7:0]  pix_mem [TOT_PIX];
    logic [8:0]  prm_mem [FRAMES];
    logic [31:0] vals    [FRAMES*OUT_PER_INDEX];
    int          extra   [FRAMES];

    logic [7:0] exp_pix [$];
    logic [9:0] exp_prm [$];
    done_t      exp_done [$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int release_cyc = 0;
    bit core_answer = 1'b0;
    int core_beat = 0;
    int core_b = 0;

    always @(posedge clk) begin
        mem_rdata <= pix_mem[mem_addr];
        prm_rdata <= prm_mem[prm_addr];
        cyc       <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event not expected or not seen", name);
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_outputs"},
            {busy, done, mem_addr, prm_addr, ifc.in_valid_data, ifc.data,
             ifc.in_valid_param, ifc.index, ifc.mode, ifc.QP, timeout_err, overlap_err},
            64'd0);
        chk({name, "_checksum"}, checksum, 64'd0);
    endtask

    // Reference: pixels in address order, 4 beats per burst, checksum = sum of first 1024 words per burst
    task automatic setup_pattern(input bit answer);
        logic [31:0] sum;
        done_t       d;
        sum = 32'd0;
        for (int i = 0; i < TOT_PIX; i++) begin
            pix_mem[i] = 8'($urandom);
            exp_pix.push_back(pix_mem[i]);
        end
        for (int b = 0; b < FRAMES; b++) prm_mem[b] = 9'($urandom);
        prm_mem[5] = {5'd17, 4'b1010};
        for (int b = 0; b < FRAMES; b++) begin
            extra[b] = (b == 3 || b == 7) ? 3 : 0;
            if (answer || b == 0) begin
                exp_prm.push_back({4'(b), prm_mem[b][8:4], prm_mem[b][0]});
                for (int m = 1; m < 4; m++) exp_prm.push_back({4'd0, 5'd0, prm_mem[b][m]});
            end
            for (int w = 0; w < OUT_PER_INDEX; w++) begin
                vals[b*OUT_PER_INDEX+w] = (b == 2 || b == 9) ? 32'hFFFF_FFFF : $urandom;
                sum += vals[b*OUT_PER_INDEX+w];
            end
        end
        d.sum = answer ? sum : 32'd0;
        d.to  = !answer;
        d.ov  = 1'b0;
        exp_done.push_back(d);
    endtask

    task automatic respond(input int b);
        int w;
        w = 0;
        while (w < OUT_PER_INDEX + extra[b]) begin
            @(negedge clk);
            if (w < OUT_PER_INDEX && $urandom_range(15) == 0) begin
                ifc.out_valid = 1'b0;
                ifc.out_value = 32'd0;
            end else begin
                ifc.out_valid = 1'b1;
                ifc.out_value = (w < OUT_PER_INDEX) ? vals[b*OUT_PER_INDEX+w] : (32'h0BAD_0000 | 32'(w));
                w++;
            end
        end
        @(negedge clk);
        ifc.out_valid = 1'b0;
        ifc.out_value = 32'd0;
        release_cyc   = cyc;
    endtask

    // Core model: answers each completed 4-beat parameter burst
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && ifc.in_valid_param) begin
                if (core_beat == 0) begin
                    core_b = int'(ifc.index);
                    if (core_answer && core_b > 0) chk("pfetch_release_latency", 64'(cyc - release_cyc), 64'd2);
                end
                core_beat++;
                if (core_beat == 4) begin
                    core_beat = 0;
                    if (core_answer) respond(core_b);
                end
            end
        end
    end

    // Monitor: pops expected beats and completion records as the DUT presents them
    initial begin
        logic [7:0] ep;
        logic [9:0] eq;
        done_t      ed;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ifc.in_valid_data && ifc.in_valid_param) fail_now("strobes_together");
                if (ifc.in_valid_data) begin
                    if (exp_pix.size() == 0) fail_now("pix_unexpected");
                    else begin
                        ep = exp_pix.pop_front();
                        chk("pix_data", ifc.data, ep);
                    end
                end else chk("data_quiet", ifc.data, 64'd0);
                if (ifc.in_valid_param) begin
                    if (exp_prm.size() == 0) fail_now("param_unexpected");
                    else begin
                        eq = exp_prm.pop_front();
                        chk("param_beat", {ifc.index, ifc.QP, ifc.mode}, eq);
                    end
                end else chk("param_quiet", {ifc.index, ifc.QP, ifc.mode}, 64'd0);
                if (done) begin
                    if (exp_done.size() == 0) fail_now("done_unexpected");
                    else begin
                        ed = exp_done.pop_front();
                        chk("done_checksum", checksum, ed.sum);
                        chk("done_timeout_err", timeout_err, ed.to);
                        chk("done_overlap_err", overlap_err, ed.ov);
                        chk("done_busy_low", busy, 64'd0);
                    end
                end
            end
        end
    end

    task automatic run_pattern(input bit answer);
        int n, first_d, last_d, first_p, first_to;
        bit got_done;
        core_answer = answer;
        setup_pattern(answer);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 64'd1);
        chk("start_mem_addr", mem_addr, 64'd0);
        n = 0; first_d = -1; last_d = -1; first_p = -1; first_to = -1; got_done = 1'b0;
        while (!got_done && n < 60000) begin
            if (n == 100) start = 1'b1;
            if (n == 101) start = 1'b0;
            if (n == 1) chk("busy_t1", busy, 64'd1);
            if (ifc.in_valid_data && first_d < 0) first_d = n;
            if (ifc.in_valid_data) last_d = n;
            if (ifc.in_valid_param && first_p < 0) first_p = n;
            if (timeout_err && first_to < 0) first_to = n;
            if (done) got_done = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk("done_seen", got_done, 64'd1);
        chk("first_data_cycle", 64'(first_d), 64'd2);
        chk("last_data_cycle", 64'(last_d), 64'd16385);
        chk("first_param_cycle", 64'(first_p), 64'd16388);
        if (!answer) begin
            chk("timeout_cycle", 64'(first_to), 64'd36391);
            chk("timeout_done_cycle", 64'(n), 64'd36391);
        end
        @(negedge clk);
        chk("after_done_pulse", done, 64'd0);
        chk("after_done_busy", busy, 64'd0);
        chk("pix_queue_empty", 64'(exp_pix.size()), 64'd0);
        chk("prm_queue_empty", 64'(exp_prm.size()), 64'd0);
        chk("done_queue_empty", 64'(exp_done.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        ifc.out_valid = 1'b0;
        ifc.out_value = 32'd0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rst = 1'b0;

        // Abort a pattern mid-DATA after provoking an overlap
        core_answer = 1'b1;
        setup_pattern(1'b1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3000) @(negedge clk);
        ifc.out_valid = 1'b1;
        ifc.out_value = 32'h5;
        @(negedge clk);
        ifc.out_valid = 1'b0;
        ifc.out_value = 32'd0;
        chk("overlap_in_data", overlap_err, 64'd1);
        chk("overlap_no_accum", checksum, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_pix.delete();
        exp_prm.delete();
        exp_done.delete();
        @(negedge clk);
        chk_quiet("mid_reset");
        rst = 1'b0;
        @(negedge clk);

        run_pattern(1'b1);
        run_pattern(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1500000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
